// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests and a prefetch FIFO feeding decode.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_stall / perf_flushed counters.
module if_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  fillPtr_q, fillPtr_d;
  logic [CNT_W-1:0]  allocPtr_q, allocPtr_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [DATA_W-1:0] instrMem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pcMem_q    [FIFO_DEPTH];

  logic             active, issueRoom, reqFire, rspTake, rspDrop, rspPush;
  logic             redirTake, fifoEmpty, pop;
  logic [CNT_W-1:0] fifoCnt;
  logic [PTR_W-1:0] rdIdx;

  // Slots are claimed in the PC queue at request time and filled with data when the response returns.
  assign fifoCnt   = fillPtr_q - rdPtr_q;
  assign fifoEmpty = (fifoCnt == '0);
  assign rdIdx     = rdPtr_q[PTR_W-1:0];
  assign active    = (state_q != IDLE);
  assign issueRoom = ({1'b0, fifoCnt} + {1'b0, outstanding_q}) < DEPTH_C;
  assign reqFire   = imem_req_valid & imem_req_ready;
  assign rspTake   = imem_rsp_valid & active & (outstanding_q != '0);
  assign rspDrop   = rspTake & (discard_q != '0);
  assign rspPush   = rspTake & ~rspDrop;
  assign redirTake = redirect_valid & active;
  assign id_valid  = ~fifoEmpty & ~redirect_valid;
  assign pop       = id_valid & id_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && enable) begin
          state_d = RUN;
        end
      end
      RUN, FLUSH: begin
        if (redirTake) begin
          state_d = (discard_d != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH && discard_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = ((state_q == RUN) || (state_q == FLUSH)) && enable && issueRoom;
    busy           = (state_q != IDLE);
  end

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspTake);
    pc_d          = pc_q;
    rdPtr_d       = rdPtr_q;
    fillPtr_d     = fillPtr_q;
    allocPtr_d    = allocPtr_q;
    discard_d     = discard_q;
    // A redirect discards everything still in flight, including a request firing this very cycle.
    if (redirTake) begin
      pc_d       = redirect_pc & ~ADDR_W'(3);
      rdPtr_d    = '0;
      fillPtr_d  = '0;
      allocPtr_d = '0;
      discard_d  = outstanding_d;
    end else begin
      if (reqFire) begin
        pc_d       = pc_q + ADDR_W'(4);
        allocPtr_d = allocPtr_q + CNT_W'(1);
      end
      if (rspPush) begin
        fillPtr_d = fillPtr_q + CNT_W'(1);
      end
      if (rspDrop) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      rdPtr_q       <= '0;
      fillPtr_q     <= '0;
      allocPtr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rdPtr_q       <= rdPtr_d;
      fillPtr_q     <= fillPtr_d;
      allocPtr_q    <= allocPtr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reqFire && !redirTake) begin
      pcMem_q[allocPtr_q[PTR_W-1:0]] <= pc_q;
    end
    if (rspPush && !redirTake) begin
      instrMem_q[fillPtr_q[PTR_W-1:0]] <= imem_rsp_data;
    end
  end

  assign imem_req_addr = pc_q;
  assign id_instr      = fifoEmpty ? '0 : instrMem_q[rdIdx];
  assign id_pc         = fifoEmpty ? '0 : pcMem_q[rdIdx];
  assign id_pc_plus4   = fifoEmpty ? '0 : pcMem_q[rdIdx] + ADDR_W'(4);

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q, flushed_q;
  logic [32:0] flushSum;

  // Flushed work counts dropped responses, FIFO entries cleared and a response landing in a redirect cycle.
  assign flushSum = {1'b0, flushed_q} + 33'(rspDrop) + 33'(rspPush & redirTake)
                  + (redirTake ? 33'(fifoCnt) : 33'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      if (pop && fetched_q != '1) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (state_q == RUN && imem_req_valid && !imem_req_ready && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
      flushed_q <= flushSum[32] ? '1 : flushSum[31:0];
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed table, corner sequences and random traffic
// compared against a queue-based model of the fetch stream.
module tb_if_fetch_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetched, perfStall, perfFlushed;
`endif

  if_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .busy           (busy)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perfFetched),
    .perf_stall     (perfStall),
    .perf_flushed   (perfFlushed)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } memReq_t;
  typedef struct { logic [31:0] addr; bit keep; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct {
    bit st, en, rdy, idr;
    bit eReqValid; logic [31:0] eAddr;
    bit eIdValid;  logic [31:0] eIdPc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastDue = 0;
  int latMin = 1;
  int latMax = 1;
  int fireCount = 0;

  memReq_t memQ[$];
  flight_t inflight[$];
  entry_t  mFifo[$];
  bit      running = 1'b0;
  logic [31:0] mPc = '0;
  logic [31:0] popLog[$];
  logic [31:0] plusLog[$];
  logic [31:0] fireLog[$];

  bit          sReqValid, sExpReqValid, sExpIdValid;
  logic [31:0] sAddr;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the rising edge; the memory returns due responses in order.
  task automatic applyStimulus(input bit st, input bit en, input bit rdy, input bit idr,
                               input bit rv, input logic [31:0] rpc);
    @(negedge clock);
    start          = st;
    enable         = en;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(memQ[0].addr);
      memQ.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic checkOutput();
    sExpReqValid = running && enable && ((mFifo.size() + inflight.size()) < DEPTH);
    sExpIdValid  = (mFifo.size() > 0) && !redirect_valid;
    check("req_valid", 32'(imem_req_valid), 32'(sExpReqValid));
    check("req_addr", imem_req_addr, mPc);
    check("busy", 32'(busy), 32'(running));
    check("id_valid", 32'(id_valid), 32'(sExpIdValid));
    if (sExpIdValid) begin
      check("id_instr", id_instr, mFifo[0].instr);
      check("id_pc", id_pc, mFifo[0].pc);
      check("id_pc_plus4", id_pc_plus4, mFifo[0].pc + 32'd4);
    end
    check("fifo_bound", (32'(dut.fifoCnt) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    sReqValid = imem_req_valid;
    sAddr     = imem_req_addr;
    if (id_valid && id_ready) begin
      popLog.push_back(id_pc);
      plusLog.push_back(id_pc_plus4);
    end
  endtask

  task automatic updateModel();
    flight_t f;
    int      d;
    @(posedge clock);
    if (sReqValid && imem_req_ready) begin
      d = cyc + $urandom_range(latMax, latMin);
      if (d <= lastDue) d = lastDue + 1;
      lastDue = d;
      memQ.push_back('{sAddr, d});
      fireCount++;
      fireLog.push_back(sAddr);
    end
    if (!running) begin
      if (start && enable) running = 1'b1;
    end else begin
      if (sExpIdValid && id_ready) mFifo.delete(0);
      if (imem_rsp_valid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.keep) mFifo.push_back('{f.addr, memData(f.addr)});
      end
      if (sExpReqValid && imem_req_ready) begin
        inflight.push_back('{mPc, 1'b1});
        mPc = mPc + 32'd4;
      end
      if (redirect_valid) begin
        mFifo.delete();
        for (int i = 0; i < inflight.size(); i++) inflight[i].keep = 1'b0;
        mPc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
    cyc++;
  endtask

  task automatic runCycle(input bit st, input bit en, input bit rdy, input bit idr,
                          input bit rv, input logic [31:0] rpc);
    applyStimulus(st, en, rdy, idr, rv, rpc);
    checkOutput();
    updateModel();
  endtask

  // Reset is dropped mid-cycle so the outputs must clear without waiting for a clock edge.
  task automatic doReset();
    #2;
    reset = 1'b0;
    #1;
    running = 1'b0;
    mPc     = 32'h0;
    mFifo.delete();
    inflight.delete();
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'h0);
    start          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic drainIdle();
    for (int i = 0; i < 40 && memQ.size() > 0; i++) runCycle(0, 1, 1, 1, 0, 32'h0);
    repeat (2) runCycle(0, 1, 1, 1, 0, 32'h0);
  endtask

  initial begin
    vec_t vecs[7];
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [31:0] rpc;
    vecs[0] = '{1, 1, 1, 1, 0, 32'h00, 0, 32'h0};
    vecs[1] = '{1, 1, 1, 1, 1, 32'h00, 0, 32'h0};
    vecs[2] = '{1, 1, 1, 1, 1, 32'h04, 0, 32'h0};
    vecs[3] = '{1, 1, 1, 1, 1, 32'h08, 1, 32'h0};
    vecs[4] = '{1, 1, 1, 1, 1, 32'h0C, 1, 32'h4};
    vecs[5] = '{1, 1, 1, 1, 1, 32'h10, 1, 32'h8};
    vecs[6] = '{1, 1, 1, 1, 1, 32'h14, 1, 32'hC};

    doReset();
    drainIdle();

    // Basic streaming with one-cycle memory: first instruction visible two cycles after the first fire.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].st, vecs[i].en, vecs[i].rdy, vecs[i].idr, 0, 32'h0);
      checkOutput();
      check("tbl_req_valid", 32'(imem_req_valid), 32'(vecs[i].eReqValid));
      check("tbl_req_addr", imem_req_addr, vecs[i].eAddr);
      check("tbl_id_valid", 32'(id_valid), 32'(vecs[i].eIdValid));
      if (vecs[i].eIdValid) check("tbl_id_pc", id_pc, vecs[i].eIdPc);
      updateModel();
    end

    // Decode stalled: four requests fill the FIFO, then drain in order and resume at 16.
    doReset();
    drainIdle();
    fireCount = 0;
    fireLog.delete();
    runCycle(1, 1, 1, 0, 0, 32'h0);
    repeat (11) runCycle(0, 1, 1, 0, 0, 32'h0);
    check("hold_fires", 32'(fireCount), 32'd4);
    popLog.delete();
    repeat (8) runCycle(0, 1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) check("drain_pc", qAt(popLog, i), 32'(i * 4));
    check("resume_addr", qAt(fireLog, 4), 32'h10);

    // Redirect with two responses in flight on a 3-cycle memory; low pc bits are ignored.
    doReset();
    drainIdle();
    latMin = 3;
    latMax = 3;
    runCycle(1, 1, 1, 1, 0, 32'h0);
    repeat (2) runCycle(0, 1, 1, 1, 0, 32'h0);
    popLog.delete();
    runCycle(0, 1, 0, 1, 1, 32'h103);
    repeat (12) runCycle(0, 1, 1, 1, 0, 32'h0);
    check("redir_first_pc", qAt(popLog, 0), 32'h100);
    check("redir_second_pc", qAt(popLog, 1), 32'h104);

    // Redirect coinciding with a response and a request fire.
    doReset();
    drainIdle();
    latMin = 1;
    latMax = 1;
    runCycle(1, 1, 1, 1, 0, 32'h0);
    repeat (6) runCycle(0, 1, 1, 1, 0, 32'h0);
    popLog.delete();
    runCycle(0, 1, 1, 1, 1, 32'h200);
    repeat (6) runCycle(0, 1, 1, 1, 0, 32'h0);
    check("same_cycle_first_pc", qAt(popLog, 0), 32'h200);

    // Address wrap at the top of the space.
    runCycle(0, 1, 1, 1, 1, 32'hFFFF_FFFC);
    fireLog.delete();
    popLog.delete();
    plusLog.delete();
    repeat (6) runCycle(0, 1, 1, 1, 0, 32'h0);
    check("wrap_fire0", qAt(fireLog, 0), 32'hFFFF_FFFC);
    check("wrap_fire1", qAt(fireLog, 1), 32'h0);
    check("wrap_pop0", qAt(popLog, 0), 32'hFFFF_FFFC);
    check("wrap_plus4", qAt(plusLog, 0), 32'h0);
    check("wrap_pop1", qAt(popLog, 1), 32'h0);

    // Reset in the middle of a flush; late responses must not leak after restart.
    doReset();
    drainIdle();
    latMin = 4;
    latMax = 4;
    runCycle(1, 1, 1, 1, 0, 32'h0);
    repeat (3) runCycle(0, 1, 1, 1, 0, 32'h0);
    runCycle(0, 1, 1, 1, 1, 32'h300);
    runCycle(0, 1, 1, 1, 0, 32'h0);
    doReset();
    latMin = 1;
    latMax = 1;
    drainIdle();
    fireLog.delete();
    runCycle(1, 1, 1, 1, 0, 32'h0);
    repeat (3) runCycle(0, 1, 1, 1, 0, 32'h0);
    check("restart_addr", qAt(fireLog, 0), 32'h0);

    // Random traffic with variable latency, stalls, enable drops and redirects.
    doReset();
    drainIdle();
    latMin = 1;
    latMax = 4;
    runCycle(1, 1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 11)) : $urandom;
      runCycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 19) == 0), rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the decode stage inside the CPU top.
- Drives the program counter and issues in-order word reads to instruction memory over a valid/ready request and a valid-only response.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after start
- FIFO_DEPTH, 4, prefetch entries (power of 2, >=2); also the max outstanding requests

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- enable  input  1  1 = new requests may issue; 0 = issue frozen
- start  input  1  leaves IDLE when high together with enable
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_W  word-aligned fetch address
- imem_rsp_valid  input  1  response data valid; in request order, >=1 cycle after acceptance
- imem_rsp_data  input  DATA_W  instruction word
- redirect_valid  input  1  taken branch/jump from downstream
- redirect_pc  input  ADDR_W  new fetch address
- id_valid  output  1  instruction available to decode
- id_ready  input  1  decode consumes
- id_instr  output  DATA_W  instruction at FIFO head
- id_pc  output  ADDR_W  address of id_instr
- id_pc_plus4  output  ADDR_W  id_pc + 4, modulo 2^ADDR_W
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; PC=RESET_PC; FIFO empty; outstanding=0; discard=0; imem_req_valid=0; id_valid=0; busy=0; imem_req_addr=RESET_PC; id_instr/id_pc/id_pc_plus4=0.
- FSM states:
  - IDLE: no requests. Go to RUN when start=1 and enable=1.
  - RUN: normal fetch.
  - FLUSH: entered on redirect while discard>0. Return to RUN when discard reaches 0.
- Request issue: imem_req_valid = (state is RUN or FLUSH) and enable and (fifo_count + outstanding < FIFO_DEPTH). imem_req_addr = PC.
- Request fire (valid & ready): PC <= PC+4, wrapping; outstanding += 1.
- Response handling: each imem_rsp_valid decrements outstanding.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise the response is pushed to the FIFO with its PC. Entry PCs are tracked in a parallel PC queue written at request time.
- Push and pop in the same cycle is legal. Overflow cannot occur by construction; the bench asserts this.
- Decode side: id_valid = FIFO non-empty and no redirect this cycle. Pop on id_valid & id_ready. Latency: response cycle N is visible at id_valid in cycle N+1; there is no bypass.
- Redirect (any state except IDLE), in the same edge:
  - FIFO cleared; PC <= redirect_pc.
  - discard <= outstanding - rsp_this_cycle + req_fire_this_cycle.
  - state <= FLUSH if that value is >0, else RUN.
  - id_valid forced 0 in the redirect cycle, so a pop is not counted.
- Redirect during FLUSH: discard is recomputed by the same rule.
- redirect_pc[1:0] is ignored; addresses are forced word-aligned.
- enable=0 mid-run: issue stops; outstanding responses are still accepted; decode handshake continues; state unchanged.
- start is ignored outside IDLE. A return to IDLE only happens via reset.
- Reset asserted mid-operation: all state clears immediately; responses arriving after reset release while in IDLE are ignored.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32-bit, increments per decode pop), perf_stall (32-bit, increments each RUN cycle with imem_req_valid=1 and imem_req_ready=0), and perf_flushed (32-bit, increments per discarded response or flushed FIFO entry). All clear on reset and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then start=1, enable=1, memory always ready, 1-cycle response, id_ready=1 -> addresses 0,4,8,...; id_pc sequence 0,4,8; id_pc_plus4 = id_pc+4; first id_valid 2 cycles after first request fire.
- id_ready=0 with ready memory -> exactly 4 requests issue, imem_req_valid drops, FIFO holds PCs 0..12; releasing id_ready drains them in order and issue resumes at PC 16.
- 3-cycle response latency with 2 outstanding, redirect_valid with redirect_pc=0x100 -> next 2 responses dropped, state FLUSH then RUN, next id_pc=0x100.
- Redirect in the same cycle as a response and a request fire -> discard count matches the rule; no stale instruction reaches decode.
- PC=0xFFFF_FFFC fetch -> next address 0x0000_0000; id_pc_plus4 of that instruction = 0.
- Reset pulled low mid-FLUSH with outstanding>0 -> all outputs return to reset values asynchronously; late responses are ignored; restart fetches from RESET_PC.
